// File: rtl/stream_packer_pkg.sv
// stream_packer_pkg: shared state encoding, framing constants and sizing helper for the stream packer
package stream_packer_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_e;
  localparam logic [7:0] SYNC_HDR = 8'hA5;
  localparam logic [7:0] SYNC_TRL = 8'h5A;
  localparam logic [7:0] TRL_PAD = 8'h00;
  localparam int HDR_CH_W = 4;
  localparam int TRL_CNT_W = 16;
  function automatic int words_per_blk(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
endpackage

// File: rtl/stream_packer_if.sv
// stream_packer_if: producer block handshake plus transmit-FIFO write port
interface stream_packer_if #(
  parameter int NUM_CH = 3,
  parameter int IN_W = 128,
  parameter int OUT_W = 32,
  parameter int TAG_W = 8
);
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH*IN_W-1:0] ch_data;
  logic [NUM_CH*TAG_W-1:0] ch_tag;
  logic frame_done;
  logic FIFO_tx_full;
  logic [OUT_W-1:0] FIFO_tx_din;
  logic FIFO_tx_enable;
  modport master (
    output ch_valid, ch_data, ch_tag, frame_done, FIFO_tx_full,
    input ch_ready, FIFO_tx_din, FIFO_tx_enable
  );
  modport slave (
    input ch_valid, ch_data, ch_tag, frame_done, FIFO_tx_full,
    output ch_ready, FIFO_tx_din, FIFO_tx_enable
  );
endinterface

// File: rtl/stream_packer_rr_arbiter.sv
// rr_arbiter: round-robin grant among requests, searching upward from the last winner with wrap
module rr_arbiter #(
  parameter int N = 3,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic         gnt_any,
  output logic [W-1:0] gnt_idx
);
  logic [W-1:0] ptr_q, ptr_d, c;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    c = ptr_q;
    for (int k = 0; k < N; k++) begin
      c = c == W'(N - 1) ? '0 : c + W'(1);
      if (req[c] && !gnt_any) begin
        gnt_any = 1'b1;
        gnt_idx = c;
      end
    end
    ptr_d = en && gnt_any ? gnt_idx : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= W'(N - 1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/stream_packer.sv
// stream_packer: frames per-channel result blocks into header/payload/trailer words for the USB transmit FIFO
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IN_W = 128,
  parameter int OUT_W = 32,
  parameter int TAG_W = 8,
  parameter int SEQ_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_packer_if.slave       bus,
  output logic                 busy,
  output logic [TRL_CNT_W-1:0] frame_pkts
);
  localparam int WORDS = words_per_blk(IN_W, OUT_W);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_e state_q, state_d;
  logic [NUM_CH-1:0] hold_valid_q, hold_valid_d;
  logic [IN_W-1:0] hold_data_q [NUM_CH];
  logic [IN_W-1:0] hold_data_d [NUM_CH];
  logic [TAG_W-1:0] hold_tag_q [NUM_CH];
  logic [TAG_W-1:0] hold_tag_d [NUM_CH];
  logic [SEQ_W-1:0] seq_q [NUM_CH];
  logic [SEQ_W-1:0] seq_d [NUM_CH];
  logic [CW-1:0] ch_sel_q, ch_sel_d, gnt_idx;
  logic [IW-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] din_q, din_d;
  logic [TRL_CNT_W-1:0] frame_pkts_q, frame_pkts_d;
  logic en_q, en_d, trailer_pending_q, trailer_pending_d;
  logic gnt_any, grant, wr_ok, last, trl_go;
  assign wr_ok = !bus.FIFO_tx_full;
  assign last = idx_q == IW'(WORDS - 1);
  assign grant = state_q == IDLE && gnt_any;
  assign trl_go = trailer_pending_q && !(|hold_valid_q) && !(|bus.ch_valid);
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk(clk), .rst(rst), .req(hold_valid_q), .en(grant), .gnt_any(gnt_any), .gnt_idx(gnt_idx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    case (state_q)
      IDLE:    state_d = gnt_any ? HEADER : trl_go ? TRAILER : IDLE;
      HEADER:  state_d = wr_ok ? PAYLOAD : HEADER;
      PAYLOAD: state_d = wr_ok && last ? IDLE : PAYLOAD;
      default: state_d = wr_ok ? IDLE : TRAILER;
    endcase
  end
  // Capture is gated by the old hold_valid, so a release never overlaps a new accept.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d = hold_data_q;
    hold_tag_d = hold_tag_q;
    seq_d = seq_q;
    ch_sel_d = grant ? gnt_idx : ch_sel_q;
    idx_d = idx_q;
    din_d = din_q;
    en_d = 1'b0;
    frame_pkts_d = frame_pkts_q;
    trailer_pending_d = trailer_pending_q | bus.frame_done;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.ch_valid[i] && !hold_valid_q[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i] = bus.ch_data[i*IN_W +: IN_W];
        hold_tag_d[i] = bus.ch_tag[i*TAG_W +: TAG_W];
      end
    if (wr_ok && state_q != IDLE) begin
      en_d = 1'b1;
      case (state_q)
        HEADER: begin
          din_d = {SYNC_HDR, HDR_CH_W'(ch_sel_q), hold_tag_q[ch_sel_q], seq_q[ch_sel_q]};
          idx_d = '0;
        end
        PAYLOAD: begin
          din_d = hold_data_q[ch_sel_q][idx_q*OUT_W +: OUT_W];
          idx_d = idx_q + IW'(1);
          if (last) begin
            hold_valid_d[ch_sel_q] = 1'b0;
            seq_d[ch_sel_q] = seq_q[ch_sel_q] + SEQ_W'(1);
            frame_pkts_d = &frame_pkts_q ? frame_pkts_q : frame_pkts_q + TRL_CNT_W'(1);
          end
        end
        default: begin
          din_d = OUT_W'({SYNC_TRL, TRL_PAD, frame_pkts_q});
          frame_pkts_d = '0;
          trailer_pending_d = bus.frame_done;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_valid_q <= '0;
      hold_data_q <= '{default: '0};
      hold_tag_q <= '{default: '0};
      seq_q <= '{default: '0};
      ch_sel_q <= '0;
      idx_q <= '0;
      din_q <= '0;
      en_q <= 1'b0;
      frame_pkts_q <= '0;
      trailer_pending_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q <= hold_data_d;
      hold_tag_q <= hold_tag_d;
      seq_q <= seq_d;
      ch_sel_q <= ch_sel_d;
      idx_q <= idx_d;
      din_q <= din_d;
      en_q <= en_d;
      frame_pkts_q <= frame_pkts_d;
      trailer_pending_q <= trailer_pending_d;
    end
  assign bus.ch_ready = ~hold_valid_q;
  assign bus.FIFO_tx_din = din_q;
  assign bus.FIFO_tx_enable = en_q;
  assign frame_pkts = frame_pkts_q;
  assign busy = state_q != IDLE || |hold_valid_q || trailer_pending_q;
endmodule
